// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter
//   Shares one valid/ack channel among NREQ requesters. Requester i holds
//   req[i] and its data in req_data[i*DW +: DW] until it sees req_done[i].
//   The winner is picked round-robin, starting one past the last served
//   requester. The winner's data is latched and held on the channel until
//   ack. A one-cycle DONE state then separates consecutive transfers.
//
// Ports
//   clk       : clock, rising edge
//   rstn      : synchronous active-low reset
//   req       : [NREQ]    per-requester request level
//   req_data  : [NREQ*DW] packed requester data
//   req_done  : [NREQ]    one-hot, one-cycle completion pulse
//   grant     : [NREQ]    one-hot owner of the channel, zero when idle
//   valid     : channel valid to downstream
//   data      : [DW]      channel data (registered)
//   ack       : downstream acknowledge
//   busy      : high while not IDLE
module handshake_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_done,
  output logic [NREQ-1:0]    grant,
  output logic               valid,
  output logic [DW-1:0]      data,
  input  logic               ack,
  output logic               busy
);

  localparam int LW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [DW-1:0]     data_q, data_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   req_done_q, req_done_d;
  logic              busy_q, busy_d;
  logic [LW-1:0]     last_q, last_d;
  logic [LW-1:0]     owner_q, owner_d;

  // Round-robin search: first requester at or after last+1, wrapping upward.
  logic              win_found;
  logic [LW-1:0]     win_idx;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path through the block can infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!win_found && req[(int'(last_q) + off) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = LW'((int'(last_q) + off) % NREQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    data_d     = data_q;
    grant_d    = grant_q;
    req_done_d = '0;
    last_d     = last_q;
    owner_d    = owner_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = WAIT_ACK;
          valid_d          = 1'b1;
          data_d           = req_data[int'(win_idx)*DW +: DW];
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
        end
      end
      WAIT_ACK: begin
        // Channel contents stay frozen; req and req_data changes are ignored.
        if (ack) begin
          state_d    = DONE;
          valid_d    = 1'b0;
          grant_d    = '0;
          req_done_d = grant_q;
          last_d     = owner_q;
        end
      end
      DONE: begin
        // Spacer cycle: no arbitration, so the requester can drop req.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples its
  // _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      data_q     <= '0;
      grant_q    <= '0;
      req_done_q <= '0;
      busy_q     <= 1'b0;
      last_q     <= LW'(NREQ - 1);
      owner_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      grant_q    <= grant_d;
      req_done_q <= req_done_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
    end
  end

  assign valid    = valid_q;
  assign data     = data_q;
  assign grant    = grant_q;
  assign req_done = req_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// tb_handshake_rr_arbiter
//   Directed bench for handshake_rr_arbiter (NREQ=4, DW=8). Inputs change and
//   outputs are sampled 1 time unit after each rising edge.
module tb_handshake_rr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_done;
  logic [NREQ-1:0]    grant;
  logic               valid;
  logic [DW-1:0]      data;
  logic               ack;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;

  handshake_rr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .req_data (req_data),
    .req_done (req_done),
    .grant    (grant),
    .valid    (valid),
    .data     (data),
    .ack      (ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"},    32'(valid),    32'd0);
    check({tag, "_grant"},    32'(grant),    32'd0);
    check({tag, "_req_done"}, 32'(req_done), 32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
  endtask

  // One full transfer with immediate ack; req is left as the caller set it.
  task automatic do_xfer(input string tag, input logic [NREQ-1:0] exp_grant,
                         input logic [DW-1:0] exp_data);
    tick();
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_grant"}, 32'(grant), 32'(exp_grant));
    check({tag, "_data"},  32'(data),  32'(exp_data));
    ack = 1'b1;
    tick();
    check({tag, "_done"},       32'(req_done), 32'(exp_grant));
    check({tag, "_done_valid"}, 32'(valid),    32'd0);
    check({tag, "_done_busy"},  32'(busy),     32'd1);
    tick();
    check({tag, "_idle_valid"}, 32'(valid),    32'd0);
    check({tag, "_idle_done"},  32'(req_done), 32'd0);
    ack = 1'b0;
  endtask

  initial begin
    rstn     = 1'b0;
    req      = '0;
    req_data = '0;
    ack      = 1'b0;

    // Reset values
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset_data", 32'(data), 32'd0);
    rstn = 1'b1;

    // Single requester, ack three cycles after valid
    req           = 4'b0001;
    req_data[7:0] = 8'hA5;
    tick();
    check("single_valid", 32'(valid), 32'd1);
    check("single_data",  32'(data),  32'hA5);
    check("single_grant", 32'(grant), 32'b0001);
    check("single_busy",  32'(busy),  32'd1);
    tick();
    tick();
    check("single_hold_valid", 32'(valid), 32'd1);
    check("single_hold_grant", 32'(grant), 32'b0001);
    ack = 1'b1;
    tick();
    check("single_done",       32'(req_done), 32'b0001);
    check("single_done_valid", 32'(valid),    32'd0);
    check("single_done_grant", 32'(grant),    32'd0);
    ack = 1'b0;
    req = '0;
    tick();
    check_idle_outputs("single_after");

    // All requesting from fresh reset: rotation 0,1,2,3,0
    rstn = 1'b0;
    tick();
    rstn     = 1'b1;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req      = 4'b1111;
    do_xfer("all0", 4'b0001, 8'h11);
    do_xfer("all1", 4'b0010, 8'h22);
    do_xfer("all2", 4'b0100, 8'h33);
    do_xfer("all3", 4'b1000, 8'h44);
    do_xfer("all4", 4'b0001, 8'h11);

    // Move last to 2, then wrap with req=1011
    req = 4'b0100;
    do_xfer("setlast", 4'b0100, 8'h33);
    req = 4'b1011;
    do_xfer("wrap0", 4'b1000, 8'h44);
    do_xfer("wrap1", 4'b0001, 8'h11);
    do_xfer("wrap2", 4'b0010, 8'h22);

    // Stability: data and req change during WAIT_ACK (last is now 1)
    req            = 4'b0010;
    req_data[15:8] = 8'h11;
    tick();
    check("stab_grant", 32'(grant), 32'b0010);
    check("stab_data0", 32'(data),  32'h11);
    req_data[15:8] = 8'h22;
    req            = '0;
    tick();
    check("stab_data1",  32'(data),  32'h11);
    check("stab_valid1", 32'(valid), 32'd1);
    check("stab_grant1", 32'(grant), 32'b0010);
    ack = 1'b1;
    tick();
    check("stab_done", 32'(req_done), 32'b0010);
    ack = 1'b0;
    tick();

    // Stray ack in IDLE
    ack = 1'b1;
    tick();
    check_idle_outputs("stray0");
    tick();
    check_idle_outputs("stray1");
    ack = 1'b0;

    // Reset during WAIT_ACK (last is 1, so requester 2 wins first)
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req      = 4'b1111;
    tick();
    check("rstmid_grant", 32'(grant), 32'b0100);
    rstn = 1'b0;
    tick();
    check_idle_outputs("rstmid");
    check("rstmid_data", 32'(data), 32'd0);
    rstn = 1'b1;
    do_xfer("rstmid_after", 4'b0001, 8'h11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the bench cannot run away.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/handshake_rr_arbiter.md
HANDSHAKE_RR_ARBITER -- requirements
Module: handshake_rr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one valid/ack channel (2..8).
REQ-002 SHALL have parameter DW, default 8: data width per requester and on the shared channel.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on rising edge.
REQ-004 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port req, input, NREQ: per-requester transfer request, level, held until its done pulse.
REQ-006 SHALL have port req_data, input, NREQ*DW: requester i data in bits [i*DW +: DW].
REQ-007 SHALL have port req_done, output, NREQ: one-hot, one-cycle pulse when requester's transfer is acked.
REQ-008 SHALL have port grant, output, NREQ: one-hot owner of the channel; all-zero when idle.
REQ-009 SHALL have port valid, output, 1: shared channel valid to downstream.
REQ-010 SHALL have port data, output, DW: shared channel data, registered.
REQ-011 SHALL have port ack, input, 1: downstream acknowledge of the current transfer.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_ACK, DONE; all outputs registered.
REQ-014 IDLE: if req nonzero at an edge, SHALL select winner w, set grant=onehot(w), data=req_data[w], valid=1, and go to WAIT_ACK on that edge; otherwise stay IDLE.
REQ-015 Winner selection SHALL be round-robin: search starts at index (last+1) mod NREQ and wraps upward; last resets to NREQ-1 so requester 0 has top priority after reset.
REQ-016 Latency: req seen at edge k -> valid=1 in the cycle after edge k (1 cycle).
REQ-017 WAIT_ACK: valid, data, and grant SHALL hold stable until ack=1 is sampled; no timeout.
REQ-018 WAIT_ACK with ack=1: on that edge SHALL set valid=0, grant=0, req_done[w]=1, last=w, and go to DONE.
REQ-019 DONE: SHALL last exactly one cycle, perform no arbitration, clear req_done on exit, and return to IDLE.
REQ-020 Requester SHALL drop req at the edge ending DONE; a req still high in IDLE is treated as a new request.
REQ-021 req[w] deasserted during WAIT_ACK SHALL NOT abort; the latched data completes and req_done[w] still pulses.
REQ-022 Changes in req_data during WAIT_ACK SHALL NOT affect data.
REQ-023 ack sampled in IDLE or DONE SHALL be ignored.
REQ-024 Minimum spacing between consecutive valid assertions SHALL be 2 idle cycles (DONE, IDLE).
REQ-025 A requester with continuous requests SHALL be granted at most once in any NREQ consecutive transfers while all others request.
REQ-026 grant, req_done SHALL never have more than one bit set.

Reset
REQ-027 rstn=0 at an edge SHALL force state=IDLE, valid=0, data=0, grant=0, req_done=0, busy=0, last=NREQ-1.
REQ-028 Reset in WAIT_ACK SHALL abandon the transfer with no req_done pulse; outputs reach reset values at that edge.
REQ-029 First arbitration SHALL occur at the first edge with rstn=1 and req nonzero.

Verification
REQ-030 Single: req=0001, req_data[0]=8'hA5, ack 3 cycles after valid -> valid=1, data=A5, grant=0001 until ack; req_done=0001 for 1 cycle; busy low after DONE.
REQ-031 All requesting: req=1111, ack immediate each time -> grants in order 0001,0010,0100,1000,0001; data matches each requester.
REQ-032 Wrap: last=2, req=1011 -> grant=1000, then 0001, then 0010.
REQ-033 Stability: req_data[1] changes 8'h11->8'h22 and req[1] drops during WAIT_ACK -> data stays 8'h11; req_done=0010 on ack.
REQ-034 Stray ack: ack=1 while IDLE with req=0 -> no state change, valid=0.
REQ-035 Reset mid-transfer: rstn=0 in WAIT_ACK -> next cycle valid=0, grant=0, req_done=0; after release with req=1111 first grant=0001.
